// File: rtl/nios2_hex_fx_if.sv
// Avalon-MM register bus for the hex display effects stage.
// Carries address, chipselect, write_n and writedata in, and readdata out.
interface nios2_hex_fx_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );
endinterface

// File: rtl/nios2_hex_fx.sv
// Hex display effects: enable, 16-level PWM brightness, ms blink.
// Ports: clk, reset_n, bus (Avalon slave), seg_in, seg_out, blink_phase.
module nios2_hex_fx #(
  parameter int PRESCALE  = 50000,
  parameter int BLINK_RST = 500
) (
  input  logic         clk,
  input  logic         reset_n,
  nios2_hex_fx_if.slave bus,
  input  logic [7:0]   seg_in,
  output logic [7:0]   seg_out,
  output logic         blink_phase
);

  localparam int PW = $clog2(PRESCALE);

  logic          enable;
  logic          blink_en;
  logic [4:0]    bright;
  logic [15:0]   blink;
  logic [3:0]    pwm_cnt;
  logic [7:0]    shadow;
  logic [PW-1:0] pre_cnt;
  logic [15:0]   blink_cnt;

  logic          wr;
  logic          tick;
  logic          toggle;
  logic          lit;
  logic          show;
  logic [15:0]   blink_lim;
  logic [4:0]    bright_in;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign tick      = pre_cnt == PW'(PRESCALE - 1);
  assign blink_lim = (blink == 16'd0) ? 16'd1 : blink;
  assign toggle    = tick && (blink_cnt == blink_lim - 16'd1);
  assign lit       = {1'b0, pwm_cnt} < bright;
  assign show      = enable & lit & ~(blink_en & blink_phase);
  assign bright_in = (bus.writedata > 32'd16) ? 5'd16
                                              : bus.writedata[4:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b1;
      blink_en <= 1'b0;
      bright   <= 5'd16;
      blink    <= 16'(BLINK_RST);
    end else if (wr) begin
      unique case (bus.address)
        2'd0: begin
          enable   <= bus.writedata[0];
          blink_en <= bus.writedata[1];
        end
        2'd1: bright <= bright_in;
        2'd2: blink  <= bus.writedata[15:0];
        2'd3: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= 4'd0;
      shadow  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (pwm_cnt == 4'd15) shadow <= seg_in;
      seg_out <= show ? shadow : 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // A BLINK write restarts the blink cycle and wins over a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b0;
    end else if (wr && bus.address == 2'd2) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b0;
    end else if (toggle) begin
      blink_cnt   <= 16'd0;
      blink_phase <= ~blink_phase;
    end else if (tick) begin
      blink_cnt   <= blink_cnt + 16'd1;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    unique case (bus.address)
      2'd0: bus.readdata = {30'd0, blink_en, enable};
      2'd1: bus.readdata = {27'd0, bright};
      2'd2: bus.readdata = {16'd0, blink};
      2'd3: bus.readdata = {30'd0, blink_en, blink_phase};
    endcase
  end

endmodule
